// File: rtl/uart_prom_loader_pkg.sv
// Shared types and constants for the framed UART PROM loader.
package uart_prom_loader_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_ALO,
    S_AHI,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  localparam int         ADDR_FIELD_BYTES  = 2;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h5A;

  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_prom_loader_byte_word_assembler.sv
// Collects little-endian bytes into a WORD_BITS word; word_vld fires on the last byte.
module byte_word_assembler #(
  parameter int WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 byte_vld,
  input  logic [7:0]           byte_data,
  output logic                 word_vld,
  output logic [WORD_BITS-1:0] word
);

  localparam int BPW   = WORD_BITS / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WORD_BITS-1:0] shift_q;
  logic [WORD_BITS-1:0] shift_d;
  logic [CNT_W-1:0]     cnt_q;

  // New bytes enter at the top, so the first byte of a word ends up in [7:0].
  always_comb begin
    shift_d = (shift_q >> 8) | (WORD_BITS'(byte_data) << (WORD_BITS - 8));
  end

  assign word_vld = byte_vld && (cnt_q == CNT_W'(BPW - 1));
  assign word     = shift_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_vld) begin
      shift_q <= shift_d;
      cnt_q   <= word_vld ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_prom_loader.sv
// Framed byte-stream loader for the instruction PROM: SYNC, ADDR_LO, ADDR_HI, LEN, payload, CHK.
module uart_prom_loader
  import uart_prom_loader_pkg::*;
#(
  parameter int         WORD_BITS      = 16,
  parameter int         DEPTH          = 8,
  parameter int         TIMEOUT_CYCLES = 625,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  localparam int        ADDR_BITS      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_ready_i,
  output logic                 rx_ack_o,
  output logic                 we_o,
  output logic [ADDR_BITS-1:0] waddr_o,
  output logic [WORD_BITS-1:0] wdata_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam int TMO_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int ADDR_FIELD_W = 8 * ADDR_FIELD_BYTES;

  state_t                state_q, state_d;
  logic [7:0]            alo_q, len_q, wcnt_q, chk_q, chk_sum;
  logic [ADDR_BITS-1:0]  addr_q, waddr_q;
  logic [WORD_BITS-1:0]  wdata_q, word;
  logic [TMO_W-1:0]      tmo_q;
  logic                  tmo_fire, word_vld, asm_vld, asm_clear;
  logic                  we_q, done_q, error_q;
  logic [ADDR_FIELD_W-1:0] addr_field;

  assign chk_sum    = chk_add(chk_q, rx_data_i);
  assign addr_field = {rx_data_i, alo_q};
  // A byte in the expiry cycle wins over the timeout.
  assign tmo_fire   = (TIMEOUT_CYCLES != 0) && (state_q != S_SYNC) && !rx_ready_i &&
                      (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign asm_vld    = rx_ready_i && (state_q == S_DATA);
  assign asm_clear  = (state_q != S_DATA) || tmo_fire;

  byte_word_assembler #(.WORD_BITS(WORD_BITS)) u_asm (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (asm_clear),
    .byte_vld (asm_vld),
    .byte_data(rx_data_i),
    .word_vld (word_vld),
    .word     (word)
  );

  always_comb begin
    state_d = state_q;
    if (tmo_fire) begin
      state_d = S_SYNC;
    end else if (rx_ready_i) begin
      case (state_q)
        S_SYNC:  if (rx_data_i == SYNC_BYTE) state_d = S_ALO;
        S_ALO:   state_d = S_AHI;
        S_AHI:   state_d = S_LEN;
        S_LEN:   state_d = S_DATA;
        S_DATA:  if (word_vld && (wcnt_q == len_q)) state_d = S_CHK;
        S_CHK:   state_d = S_SYNC;
        default: state_d = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_SYNC;
      alo_q   <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      chk_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= word_vld;
      done_q  <= 1'b0;
      tmo_q   <= (rx_ready_i || state_q == S_SYNC || tmo_fire) ? '0 : tmo_q + 1'b1;
      if (tmo_fire) error_q <= 1'b1;
      // Writes commit as soon as a word completes; a bad checksum later does not undo them.
      if (word_vld) begin
        waddr_q <= addr_q;
        wdata_q <= word;
        addr_q  <= addr_q + 1'b1;
        wcnt_q  <= wcnt_q + 1'b1;
      end
      if (rx_ready_i) begin
        case (state_q)
          S_SYNC: if (rx_data_i == SYNC_BYTE) begin
            error_q <= 1'b0;
            chk_q   <= '0;
            wcnt_q  <= '0;
          end
          S_ALO: begin
            alo_q <= rx_data_i;
            chk_q <= chk_sum;
          end
          S_AHI: begin
            addr_q <= ADDR_BITS'(addr_field);
            chk_q  <= chk_sum;
          end
          S_LEN: begin
            len_q <= rx_data_i;
            chk_q <= chk_sum;
          end
          S_DATA: chk_q <= chk_sum;
          S_CHK: begin
            if (chk_sum == 8'h00) done_q  <= 1'b1;
            else                  error_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ack_o = rx_ready_i;
  assign busy_o   = (state_q != S_SYNC);
  assign we_o     = we_q;
  assign waddr_o  = waddr_q;
  assign wdata_o  = wdata_q;
  assign done_o   = done_q;
  assign error_o  = error_q;

endmodule
